// File: rtl/riscv_uop_pkg.sv
// Shared micro-op types for the RV32I integer pipeline.
// MUL encodings exist in every build so alu_op values stay stable.
package riscv_uop_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_AUIPC  = 5'd11,
        ALU_LINK   = 5'd12,
        ALU_MUL    = 5'd13,
        ALU_MULH   = 5'd14,
        ALU_MULHSU = 5'd15,
        ALU_MULHU  = 5'd16
    } alu_op_e;

    typedef struct packed {
        alu_op_e           alu_op;
        logic [4:0]        rd;
        logic              writes_rd;
        logic              use_imm;
        logic              use_pc;
        logic [XLEN-1:0]   imm;
    } uop_t;

endpackage

// File: rtl/alu_ex_stage_if.sv
// Issue-to-execute handshake: one decoded uop plus forwarded operands.
interface alu_ex_stage_if;
    import riscv_uop_pkg::*;

    logic            valid;
    logic            ready;
    uop_t            uop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    modport master (
        output valid, uop, pc, rs1_data, rs2_data,
        input  ready
    );

    modport slave (
        input  valid, uop, pc, rs1_data, rs2_data,
        output ready
    );

endinterface

// File: rtl/alu_core.sv
// Combinational RV32I ALU; multiply ops only when ALU_MUL_EN is defined,
// otherwise their encodings return 0 like any undefined op.
module alu_core
    import riscv_uop_pkg::*;
(
    input  alu_op_e         alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

`ifdef ALU_MUL_EN
    logic signed [2*XLEN-1:0] p_ss;
    logic signed [2*XLEN-1:0] p_su;
    logic [2*XLEN-1:0]        p_uu;

    // Sign-extend into 64 bits, then one wide multiply per flavour
    assign p_ss = $signed({{XLEN{a[XLEN-1]}}, a})
                * $signed({{XLEN{b[XLEN-1]}}, b});
    assign p_su = $signed({{XLEN{a[XLEN-1]}}, a})
                * $signed({{XLEN{1'b0}}, b});
    assign p_uu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
`endif

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'd0, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_LUI:   result = b;
            ALU_AUIPC: result = pc + b;
            ALU_LINK:  result = pc + 32'd4;
`ifdef ALU_MUL_EN
            ALU_MUL:    result = p_ss[XLEN-1:0];
            ALU_MULH:   result = p_ss[2*XLEN-1:XLEN];
            ALU_MULHSU: result = p_su[2*XLEN-1:XLEN];
            ALU_MULHU:  result = p_uu[2*XLEN-1:XLEN];
`endif
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Single-cycle execute stage: operand mux, result register, forwarding.
// Optional multiply ops via ALU_MUL_EN (see alu_core).
module alu_ex_stage
    import riscv_uop_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_ex_stage_if.slave       issue,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic                o_alu_fwd_writes_rd,
    output logic [4:0]          o_alu_fwd_rd,
    output logic [XLEN-1:0]     o_alu_fwd_result,
    output logic                o_valid,
    output logic [XLEN-1:0]     o_alu_result,
    output uop_t                o_uop_forward
);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] result;

    assign issue.ready = !i_stall;

    assign a = issue.uop.use_pc  ? issue.pc      : issue.rs1_data;
    assign b = issue.uop.use_imm ? issue.uop.imm : issue.rs2_data;

    alu_core u_core (
        .alu_op (issue.uop.alu_op),
        .a      (a),
        .b      (b),
        .pc     (issue.pc),
        .result (result)
    );

    // Flush only kills valid; data may hold stale values harmlessly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid       <= 1'b0;
            o_alu_result  <= '0;
            o_uop_forward <= '0;
        end else if (i_flush) begin
            o_valid       <= 1'b0;
        end else if (!i_stall) begin
            o_valid       <= issue.valid;
            o_alu_result  <= result;
            o_uop_forward <= issue.uop;
        end
    end

    assign o_alu_fwd_writes_rd = o_valid && o_uop_forward.writes_rd
                              && (o_uop_forward.rd != 5'd0);
    assign o_alu_fwd_rd        = o_uop_forward.rd;
    assign o_alu_fwd_result    = o_alu_result;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed vector bench for alu_ex_stage plus stall/flush/reset sequences.
module tb_alu_ex_stage;
    import riscv_uop_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_stall;
    logic        i_flush;
    logic        fwd_wr;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_res;
    logic        o_valid;
    logic [31:0] o_alu_result;
    uop_t        o_uop_forward;

    int n_run;
    int n_fail;

    alu_ex_stage_if ifc ();

    alu_ex_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .issue               (ifc.slave),
        .i_stall             (i_stall),
        .i_flush             (i_flush),
        .o_alu_fwd_writes_rd (fwd_wr),
        .o_alu_fwd_rd        (fwd_rd),
        .o_alu_fwd_result    (fwd_res),
        .o_valid             (o_valid),
        .o_alu_result        (o_alu_result),
        .o_uop_forward       (o_uop_forward)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        alu_op_e     op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        use_imm;
        logic        use_pc;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input alu_op_e op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc,
                         input logic [31:0] imm, input logic use_imm,
                         input logic use_pc, input logic [4:0] rd,
                         input logic wr);
        ifc.valid            = 1'b1;
        ifc.uop.alu_op       = op;
        ifc.uop.rd           = rd;
        ifc.uop.writes_rd    = wr;
        ifc.uop.use_imm      = use_imm;
        ifc.uop.use_pc       = use_pc;
        ifc.uop.imm          = imm;
        ifc.pc               = pc;
        ifc.rs1_data         = rs1;
        ifc.rs2_data         = rs2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input alu_op_e op,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic use_imm, input logic use_pc,
                           input logic [4:0] rd, input logic wr,
                           input logic [31:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.rs1 = rs1; v.rs2 = rs2;
        v.pc = pc; v.imm = imm; v.use_imm = use_imm; v.use_pc = use_pc;
        v.rd = rd; v.wr = wr; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] mulhu_exp;
        logic [31:0] mul_exp;
        n_run  = 0;
        n_fail = 0;
`ifdef ALU_MUL_EN
        mulhu_exp = 32'hFFFF_FFFE;
        mul_exp   = 32'hFFFF_FFFA;
`else
        mulhu_exp = 32'h0;
        mul_exp   = 32'h0;
`endif
        add_vec("add",    ALU_ADD,  32'd5, 32'd7, 0, 0, 0, 0, 5'd3, 1, 32'd12);
        add_vec("sra",    ALU_SRA,  32'h8000_0000, 32'd4, 0, 0, 0, 0, 5'd4, 1,
                32'hF800_0000);
        add_vec("slt",    ALU_SLT,  32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 5'd5, 1,
                32'd1);
        add_vec("sltu",   ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 5'd5, 1,
                32'd0);
        add_vec("sub",    ALU_SUB,  32'd0, 32'd1, 0, 0, 0, 0, 5'd6, 1,
                32'hFFFF_FFFF);
        add_vec("auipc",  ALU_AUIPC, 32'hDEAD, 0, 32'h100, 32'h2000, 1, 1,
                5'd7, 1, 32'h2100);
        add_vec("link",   ALU_LINK, 32'hDEAD, 0, 32'h100, 0, 0, 1, 5'd1, 1,
                32'h104);
        add_vec("lui",    ALU_LUI,  32'h1234, 32'h5, 0, 32'hABCD_E000, 1, 0,
                5'd8, 1, 32'hABCD_E000);
        add_vec("sll_b5", ALU_SLL,  32'd1, 32'h21, 0, 0, 0, 0, 5'd9, 1, 32'd2);
        add_vec("srl",    ALU_SRL,  32'h8000_0000, 32'd4, 0, 0, 0, 0, 5'd9, 1,
                32'h0800_0000);
        add_vec("xor",    ALU_XOR,  32'hF0F0, 32'hFF00, 0, 0, 0, 0, 5'd10, 1,
                32'h0FF0);
        add_vec("or",     ALU_OR,   32'hF0F0, 32'hFF00, 0, 0, 0, 0, 5'd10, 1,
                32'hFFF0);
        add_vec("and",    ALU_AND,  32'hF0F0, 32'hFF00, 0, 0, 0, 0, 5'd10, 1,
                32'hF000);
        add_vec("add_pc_imm", ALU_ADD, 32'h5, 32'h7, 32'h200, 32'h10, 1, 1,
                5'd11, 1, 32'h210);
        add_vec("add_rd0", ALU_ADD, 32'd2, 32'd3, 0, 0, 0, 0, 5'd0, 1, 32'd5);
        add_vec("add_nowr", ALU_ADD, 32'd2, 32'd4, 0, 0, 0, 0, 5'd12, 0, 32'd6);
        add_vec("mulhu",  ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0,
                5'd13, 1, mulhu_exp);
        add_vec("mul",    ALU_MUL,  32'd3, 32'hFFFF_FFFE, 0, 0, 0, 0,
                5'd13, 1, mul_exp);
        add_vec("undef",  alu_op_e'(5'd31), 32'd3, 32'd4, 0, 0, 0, 0,
                5'd14, 1, 32'd0);

        rst_n     = 1'b0;
        i_stall   = 1'b0;
        i_flush   = 1'b0;
        ifc.valid = 1'b0;
        ifc.uop   = '0;
        ifc.pc    = '0;
        ifc.rs1_data = '0;
        ifc.rs2_data = '0;
        #12;
        chk("rst_valid",  {31'd0, o_valid}, 0);
        chk("rst_result", o_alu_result, 0);
        chk("rst_uop",    o_uop_forward[31:0], 0);
        chk("rst_fwd_wr", {31'd0, fwd_wr}, 0);
        chk("rst_fwd_rd", {27'd0, fwd_rd}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back vectors, one accepted per cycle
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].pc,
                  vecs[i].imm, vecs[i].use_imm, vecs[i].use_pc,
                  vecs[i].rd, vecs[i].wr);
            chk({vecs[i].name, "_ready"}, {31'd0, ifc.ready}, 1);
            step();
            chk({vecs[i].name, "_valid"}, {31'd0, o_valid}, 1);
            chk(vecs[i].name, o_alu_result, vecs[i].exp);
            chk({vecs[i].name, "_fwd_res"}, fwd_res, vecs[i].exp);
            chk({vecs[i].name, "_fwd_rd"}, {27'd0, fwd_rd}, {27'd0, vecs[i].rd});
            chk({vecs[i].name, "_fwd_wr"}, {31'd0, fwd_wr},
                {31'd0, vecs[i].wr && (vecs[i].rd != 5'd0)});
        end

        @(negedge clk);
        ifc.valid = 1'b0;
        step();
        chk("idle_valid", {31'd0, o_valid}, 0);
        chk("idle_fwd_wr", {31'd0, fwd_wr}, 0);

        // Stall holds outputs and drops ready
        @(negedge clk);
        drive(ALU_ADD, 32'd1, 32'd1, 0, 0, 0, 0, 5'd4, 1);
        step();
        chk("pre_stall", o_alu_result, 32'd2);
        @(negedge clk);
        drive(ALU_ADD, 32'd10, 32'd10, 0, 0, 0, 0, 5'd6, 1);
        i_stall = 1'b1;
        #1;
        chk("stall_ready", {31'd0, ifc.ready}, 0);
        step();
        chk("stall_valid", {31'd0, o_valid}, 1);
        chk("stall_hold", o_alu_result, 32'd2);
        chk("stall_rd", {27'd0, fwd_rd}, 32'd4);
        @(negedge clk);
        i_stall = 1'b0;
        step();
        chk("unstall", o_alu_result, 32'd20);

        // Flush beats an accept
        @(negedge clk);
        i_flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, o_valid}, 0);
        chk("flush_fwd_wr", {31'd0, fwd_wr}, 0);
        @(negedge clk);
        i_flush = 1'b0;
        step();
        chk("post_flush", {31'd0, o_valid}, 1);

        // Flush beats stall
        @(negedge clk);
        i_flush = 1'b1;
        i_stall = 1'b1;
        step();
        chk("flush_stall", {31'd0, o_valid}, 0);
        @(negedge clk);
        i_flush = 1'b0;
        i_stall = 1'b0;
        step();
        chk("refill", {31'd0, o_valid}, 1);

        // Asynchronous reset mid-stream
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, o_valid}, 0);
        chk("async_fwd_wr", {31'd0, fwd_wr}, 0);
        chk("async_result", o_alu_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.valid = 1'b0;
        step();
        chk("after_rst", {31'd0, o_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
